// File: rtl/asmcvd_opgen_if.sv
// Operand-pair valid/ready channel between asmcvd_opgen and its consumer.
interface asmcvd_opgen_if;
    logic       op_valid_o;
    logic       op_ready_i;
    logic [7:0] operand_1;
    logic [7:0] operand_2;

    modport master (output op_valid_o, output operand_1, output operand_2, input op_ready_i);
    modport slave  (input op_valid_o, input operand_1, input operand_2, output op_ready_i);
endinterface

// File: rtl/asmcvd_opgen.sv
// asmcvd_opgen: LFSR-driven operand-pair burst generator on a valid/ready channel.
// One burst of NUM_PAIRS accepted pairs per start request, with GAP idle
// cycles after each non-final accept.
// Optional build macro ASMCVD_OPGEN_FULL_RANGE_EN: operands are the raw LFSR
// bytes (0..255) instead of the default 1..8 mapping.
module asmcvd_opgen #(
    parameter int          NUM_PAIRS = 11,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          GAP       = 0
) (
    input  logic                  clk_100meg,
    input  logic                  sync_rst_ni,
    input  logic                  start_i,
    asmcvd_opgen_if.master        op,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           pair_cnt_o
);

    localparam logic [15:0] NP16 = 16'(NUM_PAIRS);
    localparam logic [7:0]  GAP8 = 8'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [15:0] pair_cnt;
    logic [7:0]  gap_cnt;
    logic        load, accept, last;

    // Galois step and handshake qualifiers; valid is a pure decode of the
    // registered state, so ready never reaches valid combinationally.
    always_comb begin
        lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        load     = ((state == S_IDLE) || (state == S_DONE)) && start_i;
        accept   = (state == S_SEND) && op.op_ready_i;
        last     = ((pair_cnt + 16'd1) == NP16);
    end

    // State register
    always_ff @(posedge clk_100meg) begin
        if (!sync_rst_ni) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic; the final accept skips the gap and goes straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start_i) state_nxt = S_SEND;
            S_SEND: begin
                if (accept) begin
                    if (last)         state_nxt = S_DONE;
                    else if (GAP > 0) state_nxt = S_GAP;
                    else              state_nxt = S_SEND;
                end
            end
            S_GAP:   if (gap_cnt == 8'd1) state_nxt = S_SEND;
            default: state_nxt = S_IDLE;
        endcase
    end

    // LFSR, pair counter and gap counter; LFSR only moves on an accepted pair
    always_ff @(posedge clk_100meg) begin
        if (!sync_rst_ni) begin
            lfsr     <= SEED;
            pair_cnt <= 16'd0;
            gap_cnt  <= 8'd0;
        end else begin
            if (load) begin
                lfsr     <= SEED;
                pair_cnt <= 16'd0;
            end else if (accept) begin
                lfsr     <= lfsr_nxt;
                pair_cnt <= pair_cnt + 16'd1;
            end
            if (accept && (state_nxt == S_GAP)) gap_cnt <= GAP8;
            else if (state == S_GAP)            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // Outputs: operands are the registered LFSR gated by the registered valid
    always_comb begin
        op.op_valid_o = (state == S_SEND);
        busy_o        = (state == S_SEND) || (state == S_GAP);
        done_o        = (state == S_DONE);
        pair_cnt_o    = pair_cnt;
        op.operand_1  = 8'd0;
        op.operand_2  = 8'd0;
        if (state == S_SEND) begin
`ifdef ASMCVD_OPGEN_FULL_RANGE_EN
            op.operand_1 = lfsr[7:0];
            op.operand_2 = lfsr[15:8];
`else
            op.operand_1 = {5'b0, lfsr[2:0]} + 8'd1;
            op.operand_2 = {5'b0, lfsr[10:8]} + 8'd1;
`endif
        end
    end

endmodule
